// File: rtl/serial_eq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_cmp_pkg
// Description : Shared state encoding and width helper for the serial
//               equality controller.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_cmp_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Bits needed to index n positions (n >= 2 gives at least 1 bit)
  function automatic int clog2w(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/serial_eq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_eq_ctrl_if
// Description : Start/done handshake and operand/result bundle for the
//               serial equality controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_eq_ctrl_if
  import serial_cmp_pkg::*;
#(
  parameter int WIDTH = 8
);

  localparam int PW = clog2w(WIDTH);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             equal;
  logic [PW-1:0]    mismatch_pos;

  modport master (
    output start, a, b,
    input  busy, done, equal, mismatch_pos
  );

  modport slave (
    input  start, a, b,
    output busy, done, equal, mismatch_pos
  );

endinterface
`default_nettype wire

// File: rtl/serial_eq_ctrl_cell.sv
`default_nettype none
// ============================================================================
// Module      : xnor_bit_cell
// Description : 1-bit XNOR equality cell, time-shared across bit positions.
// Revision    : 1.0 - initial release
// ============================================================================
module xnor_bit_cell (
  input  logic x,
  input  logic y,
  output logic eq_bit
);

  assign eq_bit = (~x | y) & (x | ~y);

endmodule
`default_nettype wire

// File: rtl/serial_eq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : serial_eq_ctrl
// Description : Compares two WIDTH-bit operands one bit per clock, LSB first,
//               through a single XNOR cell; reports equality and the lowest
//               mismatching index over a start/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_eq_ctrl
  import serial_cmp_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  serial_eq_ctrl_if.slave  bus
);

  localparam int            PW   = clog2w(WIDTH);
  localparam logic [PW-1:0] LAST = PW'(WIDTH - 1);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [PW-1:0]    idx;
  logic [PW-1:0]    pos_acc;
  logic             eq_acc;
  logic             eq_bit;
  logic             miss;
  logic             last;
  logic             eq_nxt;
  logic [PW-1:0]    pos_nxt;
  logic             busy_nxt;
  logic             done_nxt;

  // Operands shift right each scan cycle, so bit 0 always holds bit idx
  xnor_bit_cell u_cell (
    .x      (opa[0]),
    .y      (opb[0]),
    .eq_bit (eq_bit)
  );

  assign miss = ~eq_bit;
  assign last = (idx == LAST);

  // Accumulator update including the current bit, so a mismatch seen in the
  // final scan cycle still reaches the result registers on the DONE edge
  always_comb begin
    eq_nxt  = eq_acc;
    pos_nxt = pos_acc;
    if (state == ST_SCAN && miss && eq_acc) begin
      eq_nxt  = 1'b0;
      pos_nxt = idx;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (bus.start) state_nxt = ST_SCAN;
      ST_SCAN: if ((EARLY_EXIT && miss) || last) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output decode from the next state; registered below so outputs are glitch-free
  always_comb begin
    busy_nxt = (state_nxt == ST_SCAN);
    done_nxt = (state_nxt == ST_DONE);
  end

  // Registered handshake and result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.busy         <= 1'b0;
      bus.done         <= 1'b0;
      bus.equal        <= 1'b0;
      bus.mismatch_pos <= '0;
    end else begin
      bus.busy <= busy_nxt;
      bus.done <= done_nxt;
      if (state == ST_SCAN && state_nxt == ST_DONE) begin
        bus.equal        <= eq_nxt;
        bus.mismatch_pos <= eq_nxt ? '0 : pos_nxt;
      end
    end
  end

  // Operand capture, bit stepping and accumulation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa     <= '0;
      opb     <= '0;
      idx     <= '0;
      eq_acc  <= 1'b0;
      pos_acc <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            opa     <= bus.a;
            opb     <= bus.b;
            idx     <= '0;
            eq_acc  <= 1'b1;
            pos_acc <= '0;
          end
        end
        ST_SCAN: begin
          opa     <= opa >> 1;
          opb     <= opb >> 1;
          eq_acc  <= eq_nxt;
          pos_acc <= pos_nxt;
          if (!last) idx <= idx + PW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_eq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_eq_ctrl
// Description : Directed self-checking bench for serial_eq_ctrl with one
//               early-exit instance and one full-scan instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_eq_ctrl;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  bit   sel_f;

  serial_eq_ctrl_if #(.WIDTH(8)) bus_e ();
  serial_eq_ctrl_if #(.WIDTH(8)) bus_f ();

  serial_eq_ctrl #(.WIDTH(8), .EARLY_EXIT(1'b1)) dut_e (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_e.slave)
  );

  serial_eq_ctrl #(.WIDTH(8), .EARLY_EXIT(1'b0)) dut_f (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_f.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic       s_busy;
  logic       s_done;
  logic       s_equal;
  logic [2:0] s_pos;

  always_comb begin
    s_busy  = sel_f ? bus_f.busy         : bus_e.busy;
    s_done  = sel_f ? bus_f.done         : bus_e.done;
    s_equal = sel_f ? bus_f.equal        : bus_e.equal;
    s_pos   = sel_f ? bus_f.mismatch_pos : bus_e.mismatch_pos;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One job: start pulse, operands scrambled right after capture, latency counted
  task automatic do_job(input string tag, input bit use_f, input logic [7:0] av,
                        input logic [7:0] bv, input logic exp_eq,
                        input logic [2:0] exp_pos, input int exp_lat);
    int lat;
    bit seen;
    sel_f = use_f;
    @(negedge clk);
    if (use_f) begin bus_f.a = av; bus_f.b = bv; bus_f.start = 1'b1; end
    else       begin bus_e.a = av; bus_e.b = bv; bus_e.start = 1'b1; end
    @(posedge clk);
    #1;
    if (use_f) begin bus_f.start = 1'b0; bus_f.a = ~av; bus_f.b = bv; end
    else       begin bus_e.start = 1'b0; bus_e.a = ~av; bus_e.b = bv; end
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      @(negedge clk);
      if (s_done) seen = 1'b1;
      else begin
        check({tag, "_busy"}, s_busy, 1);
        @(posedge clk);
        lat++;
      end
    end
    check({tag, "_done_seen"}, seen, 1);
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_busy_at_done"}, s_busy, 0);
    check({tag, "_equal"}, s_equal, exp_eq);
    check({tag, "_pos"}, s_pos, exp_pos);
    @(negedge clk);
    check({tag, "_done_1cyc"}, s_done, 0);
    check({tag, "_equal_held"}, s_equal, exp_eq);
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    sel_f       = 1'b0;
    rst_n       = 1'b0;
    bus_e.start = 1'b0; bus_e.a = '0; bus_e.b = '0;
    bus_f.start = 1'b0; bus_f.a = '0; bus_f.b = '0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_e_busy",  bus_e.busy, 0);
    check("rst_e_done",  bus_e.done, 0);
    check("rst_e_equal", bus_e.equal, 0);
    check("rst_e_pos",   bus_e.mismatch_pos, 0);
    check("rst_f_busy",  bus_f.busy, 0);
    check("rst_f_done",  bus_f.done, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Early-exit instance
    do_job("e_a5_a5", 1'b0, 8'hA5, 8'hA5, 1'b1, 3'd0, 8);
    do_job("e_a5_a1", 1'b0, 8'hA5, 8'hA1, 1'b0, 3'd2, 3);
    do_job("e_01_00", 1'b0, 8'h01, 8'h00, 1'b0, 3'd0, 1);
    do_job("e_f0_70", 1'b0, 8'hF0, 8'h70, 1'b0, 3'd7, 8);

    // Full-scan instance
    do_job("f_f0_70", 1'b1, 8'hF0, 8'h70, 1'b0, 3'd7, 8);
    do_job("f_0f_0c", 1'b1, 8'h0F, 8'h0C, 1'b0, 3'd0, 8);
    do_job("f_a5_a1", 1'b1, 8'hA5, 8'hA1, 1'b0, 3'd2, 8);
    do_job("f_ff_ff", 1'b1, 8'hFF, 8'hFF, 1'b1, 3'd0, 8);

    // start held high, operands churn every cycle
    sel_f = 1'b1;
    @(negedge clk);
    bus_f.a = 8'h3C; bus_f.b = 8'h3C; bus_f.start = 1'b1;
    @(posedge clk);
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      check("hold1_busy", s_busy, 1);
      check("hold1_done", s_done, 0);
      bus_f.a = 8'($urandom); bus_f.b = 8'($urandom);
      @(posedge clk);
    end
    @(negedge clk);
    check("hold1_done_edge", s_done, 1);
    check("hold1_busy_low", s_busy, 0);
    check("hold1_equal", s_equal, 1);
    check("hold1_pos", s_pos, 0);
    bus_f.a = 8'h81; bus_f.b = 8'h80;
    @(posedge clk);
    @(negedge clk);
    check("hold_idle_busy", s_busy, 0);
    check("hold_idle_done", s_done, 0);
    @(posedge clk);
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      check("hold2_busy", s_busy, 1);
      check("hold2_done", s_done, 0);
      bus_f.a = 8'($urandom); bus_f.b = bus_f.a;
      @(posedge clk);
    end
    @(negedge clk);
    check("hold2_done_edge", s_done, 1);
    check("hold2_equal", s_equal, 0);
    check("hold2_pos", s_pos, 0);
    bus_f.start = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // Reset mid-scan after a result with nonzero position
    do_job("f_pre_rst", 1'b1, 8'hF0, 8'h70, 1'b0, 3'd7, 8);
    sel_f = 1'b1;
    @(negedge clk);
    bus_f.a = 8'h55; bus_f.b = 8'h55; bus_f.start = 1'b1;
    @(posedge clk);
    #1 bus_f.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("rst_mid_busy_before", s_busy, 1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy",  s_busy, 0);
    check("rst_mid_done",  s_done, 0);
    check("rst_mid_equal", s_equal, 0);
    check("rst_mid_pos",   s_pos, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      check("rst_after_no_done", s_done, 0);
      check("rst_after_no_busy", s_busy, 0);
    end
    do_job("f_post_rst", 1'b1, 8'h55, 8'h55, 1'b1, 3'd0, 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
